gcbp_corr_read_sched: RTL
=========================

Name: gcbp_corr_read_sched

Overview:
- Sequences correlator reads of the GCBP BRAM array once per frame.
- Each read pairs a current-frame sub-image line with a previous-frame line, swept over a vertical search window.
- Sits between the BRAM address decoder (frame-role outputs) and the correlator (valid/ready consumer).
- Two mirrored BRAM arrays (port B of each) serve the prev and curr reads in the same cycle.
- Emits per-offset boundary markers and a per-frame done pulse.

Parameters:
- C_VSEARCH, 2, max vertical offset R; offsets swept d = -R..+R (2R+1 offsets); legal 0..31.
- C_SUBIMAGE_LINES, 64, lines per sub-image.
- C_SUBIMAGE_OFFSET_IN_BRAM, 128, word stride between frame locations.

Ports:
- i_clk, input, 1, sole clock.
- i_resetn, input, 1, asynchronous active-low reset.
- i_new_frame, input, 1, one-cycle pulse; frame roles rotate on this edge.
- i_curr_frame_loc, input, 2, current-frame location from the address decoder.
- i_prev_frame_loc, input, 2, previous-frame location from the address decoder.
- o_rd_en, output, 1, read enable for both BRAM port-B reads.
- o_rd_addr_curr, output, 9, curr-frame read address.
- o_rd_addr_prev, output, 9, prev-frame read address.
- o_pair_valid, output, 1, BRAM read data pair is valid this cycle.
- i_pair_ready, input, 1, correlator accepts the pair.
- o_pair_offset, output, 6, signed offset d of the presented pair.
- o_pair_first, output, 1, first pair of the current offset.
- o_pair_last, output, 1, last pair of the current offset.
- o_pass_done, output, 1, one-cycle pulse when the sweep completes.
- o_overrun, output, 1, one-cycle pulse when i_new_frame arrives mid-pass.
- o_busy, output, 1, high in any state other than S_IDLE.

Behaviour:
- Reset: all outputs 0; state S_IDLE; frames_seen = 0; offset/line counters = 0.
- frames_seen: saturating 2-bit count, incremented on each i_new_frame.
- S_IDLE:
  - i_new_frame with frames_seen >= 1 (i.e. at least 2 completed frames including this one) -> S_LATCH.
  - Otherwise only the count updates.
- S_LATCH (1 cycle):
  - Latch i_curr_frame_loc and i_prev_frame_loc into r_curr_loc/r_prev_loc; these are the post-rotation values.
  - Set d = -R, y = max(0, -d) -> S_RUN.
- S_RUN, issue rule:
  - Issue when !(o_pair_valid && !i_pair_ready).
  - On issue: o_rd_en = 1; o_rd_addr_curr = r_curr_loc*128 + y; o_rd_addr_prev = r_prev_loc*128 + (y+d).
  - Address arithmetic is 9-bit, no wrap.
- Loop bounds:
  - y runs max(0,-d)..min(63,63-d); then d increments.
  - After the last y of d = +R -> S_DRAIN.
- BRAM read latency is 1:
  - o_pair_valid and the pair tags (o_pair_offset/first/last) register on the issue cycle and are presented the next cycle.
  - While stalled, o_rd_en = 0 so the BRAM output holds; tags hold.
- S_DRAIN:
  - Wait for the final pair to be accepted; pulse o_pass_done on the acceptance cycle -> S_IDLE.
  - o_pass_done may coincide with o_pair_valid && i_pair_ready of the final pair.
- Pairs per pass: sum over d of (64 - |d|); R = 2 -> 314.
- i_new_frame while o_busy:
  - Pulse o_overrun; drop any pending pair (o_pair_valid = 0 next cycle); no o_pass_done.
  - Go to S_LATCH and restart with the new locations.
- i_new_frame in the same cycle as the final acceptance: o_pass_done pulses, no overrun, then S_LATCH.
- i_resetn low mid-pass: immediate return to reset values; frames_seen cleared.
- Tags:
  - o_pair_first set for y = max(0,-d); o_pair_last set for y = min(63,63-d).
  - Both are set for a 1-line offset (only when R = 63, which is illegal, so never both).

Decomposition:
- Shared package gcbp_pkg: C_SUBIMAGE_LINES, C_SUBIMAGE_OFFSET_IN_BRAM, frame-location width (2), BRAM address width (9), sched state encodings (S_IDLE, S_LATCH, S_RUN, S_DRAIN).
- One natural sub-module, gcbp_sweep_cnt: the nested d/y counter with bound computation, step input, and first/last/done outputs.
- The FSM, issue/stall logic and output register stay in the top.

Test Plan:
- Reset then 1 i_new_frame -> no pass (o_busy stays 0). 2nd i_new_frame with curr = 1, prev = 0 -> first issue addr_curr = 128 + 2 = 130, addr_prev = 0 + 0 = 0, offset = -2, o_pair_first = 1.
- i_pair_ready held 1, R = 2 -> exactly 314 o_pair_valid cycles; last pair addr_curr = 128 + 61 = 189, addr_prev = 63, offset = +2, o_pair_last = 1; o_pass_done pulses once.
- i_pair_ready toggled 1-0-1 each cycle -> same 314 pairs in identical order, no duplicates or drops; o_rd_en = 0 on every stall cycle.
- i_new_frame at pair 100 (locs rotate to curr = 2, prev = 1) -> o_overrun pulses; restart with addr_curr = 256 + 2 = 258, addr_prev = 128; no o_pass_done for the aborted pass.
- i_resetn asserted at pair 50 -> all outputs 0 immediately; the next single i_new_frame does not start a pass.
- C_VSEARCH = 0 -> 64 pairs, offset = 0, addr_prev - addr_curr constant = (prev - curr)*128.

Source files
------------

// File: rtl/gcbp_pkg.sv
// rtl/gcbp_pkg.sv - shared constants, state encoding and address helper for the GCBP read scheduler
package gcbp_pkg;

  localparam int C_SUBIMAGE_LINES          = 64;
  localparam int C_SUBIMAGE_OFFSET_IN_BRAM = 128;
  localparam int LOC_W                     = 2;
  localparam int ADDR_W                    = 9;
  localparam int OFF_W                     = 6;
  localparam int LINE_W                    = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } sched_state_t;

  // Word address of a sub-image line inside a frame location; never wraps for legal inputs.
  function automatic logic [ADDR_W-1:0] bram_addr(input logic [LOC_W-1:0]  loc,
                                                  input logic [LINE_W-1:0] line);
    bram_addr = ADDR_W'(loc) * ADDR_W'(C_SUBIMAGE_OFFSET_IN_BRAM) + ADDR_W'(line);
  endfunction

endpackage

// File: rtl/gcbp_sweep_cnt.sv
// rtl/gcbp_sweep_cnt.sv - nested vertical-offset / line counter with per-offset line bounds
import gcbp_pkg::*;

module gcbp_sweep_cnt #(
  parameter int C_VSEARCH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     step,
  output logic signed [OFF_W-1:0]  d,
  output logic [LINE_W-1:0]        y,
  output logic                     first,
  output logic                     last,
  output logic                     done
);

  localparam logic signed [OFF_W-1:0] D_MIN     = OFF_W'(-C_VSEARCH);
  localparam logic signed [OFF_W-1:0] D_MAX     = OFF_W'(C_VSEARCH);
  localparam logic [LINE_W-1:0]       LAST_LINE = LINE_W'(C_SUBIMAGE_LINES - 1);

  // Lowest current-frame line whose partner line y+off is still inside the sub-image.
  function automatic logic [LINE_W-1:0] line_lo(input logic signed [OFF_W-1:0] off);
    line_lo = off[OFF_W-1] ? LINE_W'(-off) : '0;
  endfunction

  // Highest current-frame line whose partner line y+off is still inside the sub-image.
  function automatic logic [LINE_W-1:0] line_hi(input logic signed [OFF_W-1:0] off);
    line_hi = (off > 0) ? LAST_LINE - LINE_W'(off) : LAST_LINE;
  endfunction

  logic signed [OFF_W-1:0] d_next;

  assign d_next = d + 6'sd1;
  assign first  = (y == line_lo(d));
  assign last   = (y == line_hi(d));
  assign done   = last && (d == D_MAX);

  // Walk y across the legal window of each offset, then move to the next offset; hold once done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
      y <= '0;
    end else if (init) begin
      d <= D_MIN;
      y <= line_lo(D_MIN);
    end else if (step && !done) begin
      if (last) begin
        d <= d_next;
        y <= line_lo(d_next);
      end else begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcbp_corr_read_sched.sv
// rtl/gcbp_corr_read_sched.sv - per-frame correlator read sequencer over the mirrored GCBP BRAMs
import gcbp_pkg::*;

module gcbp_corr_read_sched #(
  parameter int C_VSEARCH = 2
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_new_frame,
  input  logic [LOC_W-1:0] i_curr_frame_loc,
  input  logic [LOC_W-1:0] i_prev_frame_loc,
  output logic             o_rd_en,
  output logic [8:0]       o_rd_addr_curr,
  output logic [8:0]       o_rd_addr_prev,
  output logic             o_pair_valid,
  input  logic             i_pair_ready,
  output logic [5:0]       o_pair_offset,
  output logic             o_pair_first,
  output logic             o_pair_last,
  output logic             o_pass_done,
  output logic             o_overrun,
  output logic             o_busy
);

  sched_state_t            state;
  logic [1:0]              frames_seen;
  logic [LOC_W-1:0]        r_curr_loc;
  logic [LOC_W-1:0]        r_prev_loc;

  logic signed [OFF_W-1:0] sweep_d;
  logic [LINE_W-1:0]       sweep_y;
  logic [LINE_W-1:0]       prev_line;
  logic                    sweep_first;
  logic                    sweep_last;
  logic                    sweep_done;
  logic                    sweep_init;
  logic                    issue;
  logic                    accept;

  // A read is issued only when the output pair slot is free or being drained this cycle;
  // a new frame pre-empts issuing because the pass is about to restart.
  assign accept      = o_pair_valid && i_pair_ready;
  assign issue       = (state == S_RUN) && !i_new_frame && !(o_pair_valid && !i_pair_ready);
  assign sweep_init  = (state == S_LATCH);
  assign prev_line   = sweep_y + $unsigned(sweep_d);

  assign o_busy         = (state != S_IDLE);
  assign o_rd_en        = issue;
  assign o_rd_addr_curr = issue ? bram_addr(r_curr_loc, sweep_y)   : '0;
  assign o_rd_addr_prev = issue ? bram_addr(r_prev_loc, prev_line) : '0;
  assign o_pass_done    = (state == S_DRAIN) && accept;

  gcbp_sweep_cnt #(
    .C_VSEARCH (C_VSEARCH)
  ) u_sweep (
    .clk   (i_clk),
    .rst_n (i_resetn),
    .init  (sweep_init),
    .step  (issue),
    .d     (sweep_d),
    .y     (sweep_y),
    .first (sweep_first),
    .last  (sweep_last),
    .done  (sweep_done)
  );

  // Frame counting, pass sequencing and the one-deep pair register that mirrors BRAM latency.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state         <= S_IDLE;
      frames_seen   <= '0;
      r_curr_loc    <= '0;
      r_prev_loc    <= '0;
      o_pair_valid  <= 1'b0;
      o_pair_offset <= '0;
      o_pair_first  <= 1'b0;
      o_pair_last   <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_overrun <= 1'b0;

      if (i_new_frame && frames_seen != 2'd3) begin
        frames_seen <= frames_seen + 2'd1;
      end

      if (issue) begin
        o_pair_valid  <= 1'b1;
        o_pair_offset <= sweep_d;
        o_pair_first  <= sweep_first;
        o_pair_last   <= sweep_last;
      end else if (accept || (i_new_frame && o_busy)) begin
        o_pair_valid  <= 1'b0;
      end

      if (i_new_frame && o_busy) begin
        // A frame landing on the final acceptance is a clean hand-off, not an overrun.
        o_overrun <= !o_pass_done;
        state     <= S_LATCH;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_new_frame && frames_seen != 2'd0) state <= S_LATCH;
          end
          S_LATCH: begin
            r_curr_loc <= i_curr_frame_loc;
            r_prev_loc <= i_prev_frame_loc;
            state      <= S_RUN;
          end
          S_RUN: begin
            if (issue && sweep_done) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (accept) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
